// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Holds the op codes, the state encoding and the operand width that the ALU instance must match.
package alu_arbiter_pkg;

    localparam int ALU_W    = 16;
    localparam int ALU_OP_W = 2;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_XOR = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, and a tie goes to the side ptr names.
// Purely combinational; the output is one-hot, or zero when nothing is requested.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, issuing one operation at a time.
// Each operation passes through accept, ALU evaluate and response handshake.
//  state   | meaning
//  ST_IDLE | waiting for a request; the winner is accepted combinationally
//  ST_EXEC | ALU inputs driven from the held operands; the result is captured at the edge
//  ST_RESP | response presented; held until resp_ready
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int OP_W  = ALU_OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OP_W-1:0]  r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OP_W-1:0]  r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             busy,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_out
);

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic [1:0]       gnt;
    logic             accept;
    logic             win_id;
    logic             win_ill;
    logic [OP_W-1:0]  win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    rr_arb2 u_rr_arb2 (
        .req (({r1_valid, r0_valid})),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign win_id  = gnt[1];
    assign win_op  = win_id ? r1_op : r0_op;
    assign win_a   = win_id ? r1_a  : r0_a;
    assign win_b   = win_id ? r1_b  : r0_b;
    assign win_ill = (win_op == OP_W'(ALU_ILL));
    assign accept  = (state == ST_IDLE) && (gnt != 2'b00);

    // Readys are gated by rst so they drop the instant reset is asserted.
    assign r0_ready   = accept && gnt[0] && !rst;
    assign r1_ready   = accept && gnt[1] && !rst;
    assign resp_valid = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = win_ill ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // alu_in1/alu_in2/alu_op double as the operand hold registers and resp_id as the held id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_op    <= '0;
            resp_id   <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                resp_id <= win_id;
                if (win_ill) begin
                    resp_err  <= 1'b1;
                    resp_data <= '0;
                end else begin
                    resp_err <= 1'b0;
                    alu_in1  <= win_a;
                    alu_in2  <= win_b;
                    alu_op   <= win_op;
                end
            end
            if (state == ST_EXEC) begin
                resp_data <= alu_out;
            end
            if ((state == ST_RESP) && resp_ready) begin
                rr_ptr <= ~resp_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* side.
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0;
    logic        r0_ready;
    logic [1:0]  r0_op = 2'b00;
    logic [15:0] r0_a = '0;
    logic [15:0] r0_b = '0;
    logic        r1_valid = 1'b0;
    logic        r1_ready;
    logic [1:0]  r1_op = 2'b00;
    logic [15:0] r1_a = '0;
    logic [15:0] r1_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_id;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        busy;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_out = 16'h0000;
        case (alu_op)
            2'b00:   alu_out = alu_in1 + alu_in2;
            2'b01:   alu_out = alu_in1 ^ alu_in2;
            2'b10:   alu_out = alu_in1 - alu_in2;
            default: alu_out = 16'h0000;
        endcase
    end

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_op      (r0_op),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_op      (r1_op),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_out    (alu_out)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string tag, input logic id, input logic [15:0] data,
                              input logic err);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " resp_id"},    32'(resp_id),    32'(id));
        check({tag, " resp_data"},  32'(resp_data),  32'(data));
        check({tag, " resp_err"},   32'(resp_err),   32'(err));
    endtask

    task automatic wait_resp(input string tag, input logic id, input logic [15:0] data);
        int n;
        n = 0;
        while (!resp_valid && n < 8) begin
            step();
            n++;
        end
        if (!resp_valid) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check_resp(tag, id, data, 1'b0);
        end
    endtask

    initial begin
        #3;
        check("rst busy", 32'(busy), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst alu_in1", 32'(alu_in1), 32'd0);
        step();
        step();
        rst = 1'b0;

        // 1: simple add, latency N+2
        r0_valid = 1'b1; r0_op = 2'b00; r0_a = 16'h0003; r0_b = 16'h0004;
        #1;
        check("t1 r0_ready", 32'(r0_ready), 32'd1);
        check("t1 r1_ready", 32'(r1_ready), 32'd0);
        step();
        r0_valid = 1'b0;
        check("t1 exec busy", 32'(busy), 32'd1);
        check("t1 exec resp_valid", 32'(resp_valid), 32'd0);
        check("t1 exec alu_in1", 32'(alu_in1), 32'h0003);
        check("t1 exec alu_in2", 32'(alu_in2), 32'h0004);
        check("t1 exec alu_op", 32'(alu_op), 32'd0);
        step();
        check_resp("t1", 1'b0, 16'h0007, 1'b0);
        step();
        check("t1 idle busy", 32'(busy), 32'd0);

        // 2: both valid after reset, r0 first then alternating
        rst = 1'b1;
        #1;
        rst = 1'b0;
        r0_valid = 1'b1; r0_op = 2'b01; r0_a = 16'hFF00; r0_b = 16'h0FF0;
        r1_valid = 1'b1; r1_op = 2'b10; r1_a = 16'h0005; r1_b = 16'h0007;
        #1;
        check("t2 first r0_ready", 32'(r0_ready), 32'd1);
        check("t2 first r1_ready", 32'(r1_ready), 32'd0);
        step();
        check("t2 exec readys", 32'({r1_ready, r0_ready}), 32'd0);
        step();
        check_resp("t2a", 1'b0, 16'hF0F0, 1'b0);
        step();
        check("t2 second r1_ready", 32'(r1_ready), 32'd1);
        check("t2 second r0_ready", 32'(r0_ready), 32'd0);
        step();
        step();
        check_resp("t2b", 1'b1, 16'hFFFE, 1'b0);
        step();
        check("t2 third r0_ready", 32'(r0_ready), 32'd1);
        check("t2 third r1_ready", 32'(r1_ready), 32'd0);
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();
        check_resp("t2c", 1'b0, 16'hF0F0, 1'b0);
        step();

        // 3: wrap-around add on r1
        r1_valid = 1'b1; r1_op = 2'b00; r1_a = 16'hFFFF; r1_b = 16'h0001;
        #1;
        check("t3 r1_ready", 32'(r1_ready), 32'd1);
        step();
        r1_valid = 1'b0;
        step();
        check_resp("t3", 1'b1, 16'h0000, 1'b0);
        step();

        // 4: illegal op bypasses the ALU, response at N+1
        r0_valid = 1'b1; r0_op = 2'b11; r0_a = 16'h1234; r0_b = 16'h0001;
        #1;
        check("t4 r0_ready", 32'(r0_ready), 32'd1);
        step();
        r0_valid = 1'b0;
        check_resp("t4", 1'b0, 16'h0000, 1'b1);
        check("t4 alu_op kept", 32'(alu_op), 32'd0);
        check("t4 alu_in1 kept", 32'(alu_in1), 32'hFFFF);
        step();

        // 5: stalled response, r1 xor 0x00FF^0x0F0F
        resp_ready = 1'b0;
        r1_valid = 1'b1; r1_op = 2'b01; r1_a = 16'h00FF; r1_b = 16'h0F0F;
        #1;
        check("t5 r1_ready", 32'(r1_ready), 32'd1);
        step();
        r1_valid = 1'b0;
        r0_valid = 1'b1; r0_op = 2'b00; r0_a = 16'h0001; r0_b = 16'h0001;
        step();
        for (int i = 0; i < 5; i++) begin
            check_resp("t5 hold", 1'b1, 16'h0FF0, 1'b0);
            check("t5 hold readys", 32'({r1_ready, r0_ready}), 32'd0);
            check("t5 hold busy", 32'(busy), 32'd1);
            step();
        end
        resp_ready = 1'b1;
        r0_valid = 1'b0;
        step();
        check("t5 release busy", 32'(busy), 32'd0);
        check("t5 release resp_valid", 32'(resp_valid), 32'd0);

        // 6: reset during EXEC discards the transaction
        r1_valid = 1'b1; r1_op = 2'b10; r1_a = 16'h0010; r1_b = 16'h0001;
        #1;
        check("t6 r1_ready", 32'(r1_ready), 32'd1);
        step();
        check("t6 exec busy", 32'(busy), 32'd1);
        r0_valid = 1'b1; r0_op = 2'b00; r0_a = 16'h0001; r0_b = 16'h0002;
        #1;
        rst = 1'b1;
        #1;
        check("t6 rst busy", 32'(busy), 32'd0);
        check("t6 rst alu_in1", 32'(alu_in1), 32'd0);
        check("t6 rst alu_op", 32'(alu_op), 32'd0);
        check("t6 rst readys", 32'({r1_ready, r0_ready}), 32'd0);
        check("t6 rst resp_valid", 32'(resp_valid), 32'd0);
        step();
        check("t6 rst resp_valid after edge", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("t6 post r0_ready", 32'(r0_ready), 32'd1);
        check("t6 post r1_ready", 32'(r1_ready), 32'd0);
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        wait_resp("t6 post", 1'b0, 16'h0003);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
